// File: rtl/din_pkg.sv
// Shared types and constants for the serial DIN receive path.
package din_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } din_state_e;

  localparam int BYTE_BITS = 8;

  function automatic int cnt_width(input int word_bits);
    return (word_bits > 1) ? $clog2(word_bits) : 1;
  endfunction

endpackage

// File: rtl/din_input_sync.sv
// Multi-stage flop synchroniser for a bundle of asynchronous single-bit inputs.
module din_input_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (reset) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/din_deserializer.sv
// Rebuilds SCLK/SYNC_n/DIN serial frames into parallel words on a valid/ready port.
module din_deserializer
  import din_pkg::*;
#(
  parameter int WORD_BITS   = 24,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk_in,
  input  logic                 sync_n_in,
  input  logic                 din_in,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W   = cnt_width(WORD_BITS);
  localparam int N_BYTES = WORD_BITS / BYTE_BITS;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic [2:0] sync_bits;
  logic       sclk_s, sync_n_s, din_s;
  logic       sclk_rise;
  logic       load_attempt;

  din_state_e           state_q, state_d;
  logic                 sclk_prev_q, sclk_prev_d;
  logic                 armed_q, armed_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] word_data_q, word_data_d;
  logic                 word_valid_q, word_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  din_input_sync #(
    .WIDTH (3),
    .STAGES(SYNC_STAGES)
  ) u_input_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in({sclk_in, sync_n_in, din_in}),
    .sync_out(sync_bits)
  );

  assign {sclk_s, sync_n_s, din_s} = sync_bits;
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // The shift register fills in arrival order; with LSB-first bytes each byte lands bit-reversed.
  function automatic logic [WORD_BITS-1:0] order_bytes(input logic [WORD_BITS-1:0] raw);
    logic [WORD_BITS-1:0] res;
    res = raw;
    if (LSB_FIRST) begin
      for (int b = 0; b < N_BYTES; b++) begin
        for (int i = 0; i < BYTE_BITS; i++) begin
          res[b*BYTE_BITS+i] = raw[b*BYTE_BITS+BYTE_BITS-1-i];
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    sclk_prev_d  = sclk_s;
    armed_d      = armed_q | sync_n_s;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    load_attempt = 1'b0;

    // armed_q demands sync_n be seen high after reset, so a frame cut by reset is not resumed.
    case (state_q)
      IDLE: begin
        if (armed_q && !sync_n_s) begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sync_n_s) begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[WORD_BITS-2:0], din_s};
          if (bit_cnt_q == LAST_BIT) begin
            load_attempt = 1'b1;
            state_d      = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (sync_n_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_attempt) begin
      if (!word_valid_q || word_ready) begin
        word_data_d  = order_bytes({shift_q[WORD_BITS-2:0], din_s});
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sclk_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_prev_q  <= sclk_prev_d;
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_din_deserializer.sv
// Drives directed serial frames into LSB-first and MSB-first receivers and checks them against a frame-level model.
module tb_din_deserializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk_in = 1'b0;
  logic sync_n_in = 1'b1;
  logic din_in = 1'b0;
  logic word_ready = 1'b1;

  logic [23:0] word_data_l, word_data_m;
  logic        word_valid_l, word_valid_m;
  logic        frame_err_l, frame_err_m;
  logic        overrun_l, overrun_m;

  always #5 clk = ~clk;

  din_deserializer #(.WORD_BITS(24), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut_lsb (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .sync_n_in(sync_n_in), .din_in(din_in),
    .word_data(word_data_l), .word_valid(word_valid_l), .word_ready(word_ready),
    .frame_err(frame_err_l), .overrun(overrun_l)
  );

  din_deserializer #(.WORD_BITS(24), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut_msb (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .sync_n_in(sync_n_in), .din_in(din_in),
    .word_data(word_data_m), .word_valid(word_valid_m), .word_ready(word_ready),
    .frame_err(frame_err_m), .overrun(overrun_m)
  );

  int checks = 0;
  int errors = 0;

  int edge_cnt = 0;
  int comp_edge = -1;
  int err_edge = -1;
  int final_rise_edge = 0;
  logic [23:0] comp_w_l = '0;
  logic [23:0] comp_w_m = '0;
  bit pulse_ready = 1'b0;
  bit model_live = 1'b0;
  bit sim_done = 1'b0;

  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_ovr = 1'b0;
  logic [23:0] exp_data_l = '0;
  logic [23:0] exp_data_m = '0;

  int valid_cnt = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int last_rise_edge = 0;
  logic [23:0] last_data_l = '0;
  logic [23:0] last_data_m = '0;
  logic prev_valid = 1'b0;

  // Expected word for a wire bit stream: bit i belongs to byte i/8, placed by the receiver's bit order.
  function automatic logic [23:0] model_word(input logic [23:0] bits, input bit lsb_first);
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < 24; i++) begin
      if (lsb_first) w[16 - 8*(i/8) + (i%8)] = bits[i];
      else           w[23 - 8*(i/8) - (i%8)] = bits[i];
    end
    return w;
  endfunction

  // Frame-level model: a completion or early end scheduled by the driver takes effect 3 edges later.
  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    if (reset) begin
      model_live = 1'b1;
      exp_valid  = 1'b0;
      exp_err    = 1'b0;
      exp_ovr    = 1'b0;
      exp_data_l = '0;
      exp_data_m = '0;
    end else begin
      exp_err = (edge_cnt == err_edge);
      exp_ovr = 1'b0;
      if (edge_cnt == comp_edge) begin
        if (!exp_valid || word_ready) begin
          exp_valid  = 1'b1;
          exp_data_l = comp_w_l;
          exp_data_m = comp_w_m;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && word_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One SCLK period of 8 clk: data set up 4 clk before the rise, SCLK high for 4 clk.
  task automatic send_bit(input logic b, input bit is_final);
    din_in = b;
    tick(4);
    sclk_in = 1'b1;
    if (is_final) begin
      final_rise_edge = edge_cnt;
      comp_edge = edge_cnt + 3;
    end
    if (is_final && pulse_ready) begin
      tick(2);
      word_ready = 1'b1;
      tick(1);
      word_ready = 1'b0;
      tick(1);
    end else begin
      tick(4);
    end
    sclk_in = 1'b0;
  endtask

  task automatic applyStimulus(input logic [23:0] bytes_in, input bit wire_lsb, input int nbits,
                               input bit expect_done);
    logic [23:0] bits;
    logic [7:0]  bt;
    for (int i = 0; i < 24; i++) begin
      bt = bytes_in[23 - 8*(i/8) -: 8];
      bits[i] = wire_lsb ? bt[i%8] : bt[7 - (i%8)];
    end
    comp_w_l = model_word(bits, 1'b1);
    comp_w_m = model_word(bits, 1'b0);
    sync_n_in = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i], expect_done && (i == 23));
    end
    tick(4);
    sync_n_in = 1'b1;
    if (!expect_done) err_edge = edge_cnt + 3;
    tick(8);
  endtask

  initial begin
    int b_valid, b_err, b_ovr;
    fork
      begin
        tick(3);
        checkOutput("reset_valid", 24'(word_valid_l), 24'h0);
        checkOutput("reset_data", word_data_l, 24'h0);
        checkOutput("reset_err", 24'(frame_err_m), 24'h0);
        checkOutput("reset_ovr", 24'(overrun_m), 24'h0);
        reset = 1'b0;
        tick(6);

        $display("[TB] nominal frame");
        word_ready = 1'b1;
        b_valid = valid_cnt;
        applyStimulus(24'hA53C0F, 1'b1, 24, 1'b1);
        checkOutput("nominal_word", last_data_l, 24'hA53C0F);
        checkOutput("nominal_valid_cycles", 24'(valid_cnt - b_valid), 24'd1);
        checkOutput("nominal_latency", 24'(last_rise_edge - final_rise_edge), 24'd3);

        $display("[TB] bit order");
        applyStimulus(24'h800001, 1'b0, 24, 1'b1);
        checkOutput("msb_first_word", last_data_m, 24'h800001);
        checkOutput("lsb_first_word", last_data_l, 24'h010080);

        $display("[TB] short frame");
        b_valid = valid_cnt;
        b_err = err_cnt;
        applyStimulus(24'h5A5A5A, 1'b1, 13, 1'b0);
        checkOutput("short_err_pulses", 24'(err_cnt - b_err), 24'd1);
        checkOutput("short_no_valid", 24'(valid_cnt - b_valid), 24'd0);
        applyStimulus(24'h123456, 1'b1, 24, 1'b1);
        checkOutput("after_short_word", last_data_l, 24'h123456);

        $display("[TB] back-pressure");
        word_ready = 1'b0;
        b_ovr = ovr_cnt;
        applyStimulus(24'h111111, 1'b1, 24, 1'b1);
        applyStimulus(24'h222222, 1'b1, 24, 1'b1);
        checkOutput("bp_held_word", word_data_l, 24'h111111);
        checkOutput("bp_overrun_pulses", 24'(ovr_cnt - b_ovr), 24'd1);
        checkOutput("bp_valid_held", 24'(word_valid_l), 24'h1);
        word_ready = 1'b1;
        tick(1);
        checkOutput("bp_valid_drop", 24'(word_valid_l), 24'h0);
        word_ready = 1'b0;

        $display("[TB] accept and complete together");
        b_ovr = ovr_cnt;
        applyStimulus(24'h111111, 1'b1, 24, 1'b1);
        pulse_ready = 1'b1;
        applyStimulus(24'h222222, 1'b1, 24, 1'b1);
        pulse_ready = 1'b0;
        checkOutput("simul_word", word_data_l, 24'h222222);
        checkOutput("simul_valid", 24'(word_valid_l), 24'h1);
        checkOutput("simul_no_overrun", 24'(ovr_cnt - b_ovr), 24'd0);
        word_ready = 1'b1;
        tick(2);

        $display("[TB] reset mid-frame");
        b_err = err_cnt;
        b_valid = valid_cnt;
        sync_n_in = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("midrst_valid", 24'(word_valid_l), 24'h0);
        checkOutput("midrst_data", word_data_l, 24'h0);
        checkOutput("midrst_err", 24'(frame_err_l), 24'h0);
        for (int i = 0; i < 26; i++) send_bit(1'b1, 1'b0);
        tick(4);
        sync_n_in = 1'b1;
        tick(8);
        checkOutput("midrst_ignored_bits", 24'(valid_cnt - b_valid), 24'd0);
        applyStimulus(24'hABCDEF, 1'b1, 24, 1'b1);
        checkOutput("midrst_next_word", last_data_l, 24'hABCDEF);
        checkOutput("midrst_no_err", 24'(err_cnt - b_err), 24'd0);
        sim_done = 1'b1;
      end
      begin
        while (!sim_done) begin
          @(negedge clk);
          if (model_live) begin
            checkOutput("valid_l", 24'(word_valid_l), 24'(exp_valid));
            checkOutput("valid_m", 24'(word_valid_m), 24'(exp_valid));
            checkOutput("data_l", word_data_l, exp_data_l);
            checkOutput("data_m", word_data_m, exp_data_m);
            checkOutput("frame_err_l", 24'(frame_err_l), 24'(exp_err));
            checkOutput("frame_err_m", 24'(frame_err_m), 24'(exp_err));
            checkOutput("overrun_l", 24'(overrun_l), 24'(exp_ovr));
            checkOutput("overrun_m", 24'(overrun_m), 24'(exp_ovr));
          end
          if (word_valid_l) begin
            valid_cnt = valid_cnt + 1;
            last_data_l = word_data_l;
            last_data_m = word_data_m;
            if (!prev_valid) last_rise_edge = edge_cnt;
          end
          prev_valid = word_valid_l;
          if (frame_err_l) err_cnt = err_cnt + 1;
          if (overrun_l) ovr_cnt = ovr_cnt + 1;
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
